// File: rtl/wb_write_arbiter_pkg.sv
// wb_arb_pkg: shared types and default widths for the register-file
// write-port arbiter.
//   - arbState_t : arbiter FSM state (ST_NORMAL / ST_FORCE)
//   - mduEntry_t : buffered MDU result {writeReg, data} at default widths.
//     The FIFO builds an equivalent struct from its own width parameters.
//   - *_DEF      : default parameter values for the arbiter and its interface
package wb_arb_pkg;

  localparam int DATA_W_DEF       = 32;
  localparam int REG_W_DEF        = 5;
  localparam int FIFO_DEPTH_DEF   = 2;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arbState_t;

  typedef struct packed {
    logic [REG_W_DEF-1:0]  writeReg;
    logic [DATA_W_DEF-1:0] data;
  } mduEntry_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if: bundles the signals between the WriteBack stage, the
// MDU, decode-stage hazard checking and the register-file write port.
//   master : environment side (drives pipe/MDU requests and queryReg)
//   slave  : arbiter side (drives stall, ready, pendingHit, RF write port)
interface wb_write_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
);

  // WriteBack stage
  logic              pipeRegWrite;
  logic [REG_W-1:0]  pipeWriteReg;
  logic [DATA_W-1:0] pipeWriteData;
  logic              pipeStall;
  // MDU result handshake
  logic              mduValid;
  logic [REG_W-1:0]  mduWriteReg;
  logic [DATA_W-1:0] mduData;
  logic              mduReady;
  // Decode-stage pending-write query
  logic [REG_W-1:0]  queryReg;
  logic              pendingHit;
  // Register-file write port
  logic              regWrite;
  logic [REG_W-1:0]  writeReg;
  logic [DATA_W-1:0] writeData;

  modport master (
    output pipeRegWrite, pipeWriteReg, pipeWriteData,
    output mduValid, mduWriteReg, mduData, queryReg,
    input  pipeStall, mduReady, pendingHit,
    input  regWrite, writeReg, writeData
  );

  modport slave (
    input  pipeRegWrite, pipeWriteReg, pipeWriteData,
    input  mduValid, mduWriteReg, mduData, queryReg,
    output pipeStall, mduReady, pendingHit,
    output regWrite, writeReg, writeData
  );

endinterface

// File: rtl/wb_write_arbiter_mdu_fifo.sv
// wb_mdu_fifo: circular buffer for MDU results awaiting a write-port slot.
// Ports:
//   clk, rst_n            clock, async active-low reset (empties the buffer)
//   push/pushReg/pushData enqueue request (ignored when full)
//   pop                   dequeue request (ignored when empty)
//   full, empty           occupancy flags
//   headReg, headData     oldest entry
//   entryValid/entryReg   per-slot occupancy and destination, for hazard matching
module wb_mdu_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [REG_W-1:0]            pushReg,
  input  logic [DATA_W-1:0]           pushData,
  input  logic                        pop,
  output logic                        full,
  output logic                        empty,
  output logic [REG_W-1:0]            headReg,
  output logic [DATA_W-1:0]           headData,
  output logic [DEPTH-1:0]            entryValid,
  output logic [DEPTH-1:0][REG_W-1:0] entryReg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [REG_W-1:0]  writeReg;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: state uses <= so every flop samples pre-edge values; blocking here
  // would make the result depend on process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy comes only from
  // count/rdPtr, so stale slot contents are never observed.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= '{writeReg: pushReg, data: pushData};
  end

  assign headReg  = mem[rdPtr].writeReg;
  assign headData = mem[rdPtr].data;

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PTR_W-1:0] offset;
    // NOTE: every output gets a default before the loop so no latch is inferred.
    entryValid = '0;
    entryReg   = '0;
    offset     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset        = PTR_W'(i) - rdPtr;
      entryValid[i] = ({1'b0, offset} < count);
      entryReg[i]   = mem[i].writeReg;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the register-file write port between the
// WriteBack stage and the MDU. MDU results queue in wb_mdu_fifo and drain
// into idle port cycles; after STARVE_LIMIT pipeline-won cycles with a
// non-empty queue, one FORCE cycle stalls the pipeline and drains the head.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus (slave)  pipe/MDU requests, pipeStall, mduReady, pendingHit and the
//                registered write port regWrite/writeReg/writeData
module wb_write_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int REG_W        = REG_W_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic               clk,
  input logic               rst_n,
  wb_write_arbiter_if.slave bus
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arbState_t                       state, stateNext;
  logic [STARVE_W-1:0]             starve, starveNext;
  logic                            grantPipe, grantMdu;
  logic                            pipeWrite, fifoPush;
  logic                            fifoFull, fifoEmpty;
  logic [REG_W-1:0]                headReg;
  logic [DATA_W-1:0]               headData;
  logic [FIFO_DEPTH-1:0]           entryValid;
  logic [FIFO_DEPTH-1:0][REG_W-1:0] entryReg;
  logic                            fifoHit;
  logic                            regWriteQ, outIsMdu;
  logic [REG_W-1:0]                writeRegQ;
  logic [DATA_W-1:0]               writeDataQ;

  // r0 writes vanish: a pipeline r0 write never competes for the port, and an
  // MDU r0 result completes its handshake without being queued.
  assign pipeWrite    = bus.pipeRegWrite && (bus.pipeWriteReg != '0);
  assign bus.mduReady = !fifoFull;
  assign fifoPush     = bus.mduValid && bus.mduReady && (bus.mduWriteReg != '0);

  wb_mdu_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifoPush),
    .pushReg    (bus.mduWriteReg),
    .pushData   (bus.mduData),
    .pop        (grantMdu),
    .full       (fifoFull),
    .empty      (fifoEmpty),
    .headReg    (headReg),
    .headData   (headData),
    .entryValid (entryValid),
    .entryReg   (entryReg)
  );

  // FSM state register, with the starvation counter alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_NORMAL;
      starve <= '0;
    end else begin
      state  <= stateNext;
      starve <= starveNext;
    end
  end

  // FSM next-state and grant decision
  always_comb begin
    stateNext  = state;
    starveNext = starve;
    grantPipe  = 1'b0;
    grantMdu   = 1'b0;
    case (state)
      ST_NORMAL: begin
        if (pipeWrite) begin
          grantPipe = 1'b1;
          if (!fifoEmpty) begin
            if (starve != STARVE_MAX) starveNext = starve + STARVE_W'(1);
            // Switch on the cycle the count reaches the limit, so the stall
            // lands on the following cycle.
            if (starveNext == STARVE_MAX) stateNext = ST_FORCE;
          end
        end else if (!fifoEmpty) begin
          grantMdu   = 1'b1;
          starveNext = '0;
        end
      end
      ST_FORCE: begin
        // Only reachable with a non-empty queue; the guard keeps a pop off an
        // empty buffer regardless.
        grantMdu   = !fifoEmpty;
        starveNext = '0;
        stateNext  = ST_NORMAL;
      end
      default: stateNext = ST_NORMAL;
    endcase
  end

  // FSM outputs: decoded from the state register only
  always_comb begin
    bus.pipeStall = (state == ST_FORCE);
  end

  // Registered write port; outIsMdu marks an MDU write still in flight to
  // the register file so the hazard check covers it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWriteQ  <= 1'b0;
      writeRegQ  <= '0;
      writeDataQ <= '0;
      outIsMdu   <= 1'b0;
    end else if (grantPipe) begin
      regWriteQ  <= 1'b1;
      writeRegQ  <= bus.pipeWriteReg;
      writeDataQ <= bus.pipeWriteData;
      outIsMdu   <= 1'b0;
    end else if (grantMdu) begin
      regWriteQ  <= 1'b1;
      writeRegQ  <= headReg;
      writeDataQ <= headData;
      outIsMdu   <= 1'b1;
    end else begin
      regWriteQ  <= 1'b0;
      outIsMdu   <= 1'b0;
    end
  end

  assign bus.regWrite  = regWriteQ;
  assign bus.writeReg  = writeRegQ;
  assign bus.writeData = writeDataQ;

  always_comb begin
    fifoHit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entryValid[i] && (entryReg[i] == bus.queryReg)) fifoHit = 1'b1;
    end
  end

  assign bus.pendingHit = (bus.queryReg != '0) &&
                          (fifoHit || (regWriteQ && outIsMdu && (writeRegQ == bus.queryReg)));

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter (defaults: depth 2, starve limit 4).
// Each table row drives one cycle of inputs just after a rising edge and
// compares all outputs at the following falling edge.
module tb_wb_write_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wb_write_arbiter_if #(.DATA_W(32), .REG_W(5)) bus ();

  wb_write_arbiter #(
    .DATA_W       (32),
    .REG_W        (5),
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        pw;
    logic [4:0]  pr;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic [4:0]  q;
    logic        eRw;
    logic [4:0]  eReg;
    logic [31:0] eData;
    logic        eStall;
    logic        eReady;
    logic        eHit;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t row(
    input logic pw, input logic [4:0] pr, input logic [31:0] pd,
    input logic mv, input logic [4:0] mr, input logic [31:0] md,
    input logic [4:0] q,
    input logic eRw, input logic [4:0] eReg, input logic [31:0] eData,
    input logic eStall, input logic eReady, input logic eHit);
    vec_t v;
    v = '{pw, pr, pd, mv, mr, md, q, eRw, eReg, eData, eStall, eReady, eHit};
    return v;
  endfunction

  task automatic drive(input logic pw, input logic [4:0] pr, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic [4:0] q);
    bus.pipeRegWrite  = pw;
    bus.pipeWriteReg  = pr;
    bus.pipeWriteData = pd;
    bus.mduValid      = mv;
    bus.mduWriteReg   = mr;
    bus.mduData       = md;
    bus.queryReg      = q;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, " regWrite"},   32'(bus.regWrite),   32'd0);
    check({tag, " writeReg"},   32'(bus.writeReg),   32'd0);
    check({tag, " writeData"},  bus.writeData,       32'd0);
    check({tag, " pipeStall"},  32'(bus.pipeStall),  32'd0);
    check({tag, " mduReady"},   32'(bus.mduReady),   32'd1);
    check({tag, " pendingHit"}, 32'(bus.pendingHit), 32'd0);
  endtask

  initial begin
    //          pw pr     pd            mv mr     md          q       eRw eReg   eData         st rd hit
    // pipeline write with no competition
    vecs.push_back(row(0, 5'd0,  32'h0,     0, 5'd0, 32'h0,    5'd0,  0, 5'd0,  32'h0,     0, 1, 0));
    vecs.push_back(row(1, 5'd5,  32'h1234,  0, 5'd0, 32'h0,    5'd0,  0, 5'd0,  32'h0,     0, 1, 0));
    vecs.push_back(row(0, 5'd0,  32'h0,     0, 5'd0, 32'h0,    5'd0,  1, 5'd5,  32'h1234,  0, 1, 0));
    // idle drain of MDU r9
    vecs.push_back(row(0, 5'd0,  32'h0,     1, 5'd9, 32'hAAAA, 5'd9,  0, 5'd0,  32'h0,     0, 1, 0));
    vecs.push_back(row(0, 5'd0,  32'h0,     0, 5'd0, 32'h0,    5'd9,  0, 5'd0,  32'h0,     0, 1, 1));
    vecs.push_back(row(0, 5'd0,  32'h0,     0, 5'd0, 32'h0,    5'd9,  1, 5'd9,  32'hAAAA,  0, 1, 1));
    vecs.push_back(row(0, 5'd0,  32'h0,     0, 5'd0, 32'h0,    5'd9,  0, 5'd0,  32'h0,     0, 1, 0));
    // r0 filter: pipe r0 loses to queued MDU r4; MDU r0 is swallowed
    vecs.push_back(row(0, 5'd0,  32'h0,     1, 5'd4, 32'h44,   5'd4,  0, 5'd0,  32'h0,     0, 1, 0));
    vecs.push_back(row(1, 5'd0,  32'hDEAD,  0, 5'd0, 32'h0,    5'd4,  0, 5'd0,  32'h0,     0, 1, 1));
    vecs.push_back(row(0, 5'd0,  32'h0,     1, 5'd0, 32'h55,   5'd4,  1, 5'd4,  32'h44,    0, 1, 1));
    vecs.push_back(row(0, 5'd0,  32'h0,     0, 5'd0, 32'h0,    5'd0,  0, 5'd0,  32'h0,     0, 1, 0));
    // backpressure: pipeline busy, MDU r1, r2, then r3 held until forced pop
    vecs.push_back(row(1, 5'd10, 32'hA0,    1, 5'd1, 32'h11,   5'd1,  0, 5'd0,  32'h0,     0, 1, 0));
    vecs.push_back(row(1, 5'd11, 32'hA1,    1, 5'd2, 32'h22,   5'd1,  1, 5'd10, 32'hA0,    0, 1, 1));
    vecs.push_back(row(1, 5'd12, 32'hA2,    1, 5'd3, 32'h33,   5'd3,  1, 5'd11, 32'hA1,    0, 0, 0));
    vecs.push_back(row(1, 5'd13, 32'hA3,    1, 5'd3, 32'h33,   5'd2,  1, 5'd12, 32'hA2,    0, 0, 1));
    vecs.push_back(row(1, 5'd14, 32'hA4,    1, 5'd3, 32'h33,   5'd1,  1, 5'd13, 32'hA3,    0, 0, 1));
    vecs.push_back(row(1, 5'd15, 32'hA5,    1, 5'd3, 32'h33,   5'd1,  1, 5'd14, 32'hA4,    1, 0, 1));
    vecs.push_back(row(1, 5'd15, 32'hA5,    1, 5'd3, 32'h33,   5'd1,  1, 5'd1,  32'h11,    0, 1, 1));
    vecs.push_back(row(1, 5'd16, 32'hA6,    0, 5'd0, 32'h0,    5'd3,  1, 5'd15, 32'hA5,    0, 0, 1));
    vecs.push_back(row(0, 5'd0,  32'h0,     0, 5'd0, 32'h0,    5'd2,  1, 5'd16, 32'hA6,    0, 0, 1));
    vecs.push_back(row(0, 5'd0,  32'h0,     0, 5'd0, 32'h0,    5'd3,  1, 5'd2,  32'h22,    0, 1, 1));
    vecs.push_back(row(0, 5'd0,  32'h0,     0, 5'd0, 32'h0,    5'd3,  1, 5'd3,  32'h33,    0, 1, 1));
    vecs.push_back(row(0, 5'd0,  32'h0,     0, 5'd0, 32'h0,    5'd0,  0, 5'd0,  32'h0,     0, 1, 0));
    // starvation: r7 queued behind continuous pipeline writes
    vecs.push_back(row(1, 5'd20, 32'hB0,    1, 5'd7, 32'h77,   5'd7,  0, 5'd0,  32'h0,     0, 1, 0));
    vecs.push_back(row(1, 5'd21, 32'hB1,    0, 5'd0, 32'h0,    5'd7,  1, 5'd20, 32'hB0,    0, 1, 1));
    vecs.push_back(row(1, 5'd22, 32'hB2,    0, 5'd0, 32'h0,    5'd7,  1, 5'd21, 32'hB1,    0, 1, 1));
    vecs.push_back(row(1, 5'd23, 32'hB3,    0, 5'd0, 32'h0,    5'd7,  1, 5'd22, 32'hB2,    0, 1, 1));
    vecs.push_back(row(1, 5'd24, 32'hB4,    0, 5'd0, 32'h0,    5'd7,  1, 5'd23, 32'hB3,    0, 1, 1));
    vecs.push_back(row(1, 5'd25, 32'hB5,    0, 5'd0, 32'h0,    5'd7,  1, 5'd24, 32'hB4,    1, 1, 1));
    vecs.push_back(row(1, 5'd25, 32'hB5,    0, 5'd0, 32'h0,    5'd7,  1, 5'd7,  32'h77,    0, 1, 1));
    vecs.push_back(row(0, 5'd0,  32'h0,     0, 5'd0, 32'h0,    5'd7,  1, 5'd25, 32'hB5,    0, 1, 0));
    vecs.push_back(row(0, 5'd0,  32'h0,     0, 5'd0, 32'h0,    5'd0,  0, 5'd0,  32'h0,     0, 1, 0));

    // Reset held with random inputs: outputs must sit at reset values
    for (int c = 0; c < 4; c++) begin
      drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom,
            5'($urandom));
      @(negedge clk);
      checkResetOutputs($sformatf("reset%0d", c));
    end
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pw, vecs[i].pr, vecs[i].pd, vecs[i].mv, vecs[i].mr, vecs[i].md, vecs[i].q);
      @(negedge clk);
      check($sformatf("row%0d regWrite", i),   32'(bus.regWrite),   32'(vecs[i].eRw));
      if (vecs[i].eRw) begin
        check($sformatf("row%0d writeReg", i),  32'(bus.writeReg),  32'(vecs[i].eReg));
        check($sformatf("row%0d writeData", i), bus.writeData,      vecs[i].eData);
      end
      check($sformatf("row%0d pipeStall", i),  32'(bus.pipeStall),  32'(vecs[i].eStall));
      check($sformatf("row%0d mduReady", i),   32'(bus.mduReady),   32'(vecs[i].eReady));
      check($sformatf("row%0d pendingHit", i), 32'(bus.pendingHit), 32'(vecs[i].eHit));
      @(posedge clk);
      #1;
    end

    // Reset mid-drain: fill both slots behind pipeline traffic, then reset
    drive(1, 5'd1, 32'hC1, 1, 5'd8, 32'h88, 5'd8);
    @(posedge clk);
    #1;
    drive(1, 5'd2, 32'hC2, 1, 5'd9, 32'h99, 5'd8);
    @(posedge clk);
    #1;
    drive(1, 5'd3, 32'hC3, 0, 5'd0, 32'h0, 5'd8);
    @(negedge clk);
    check("prerst regWrite",   32'(bus.regWrite),   32'd1);
    check("prerst writeReg",   32'(bus.writeReg),   32'd2);
    check("prerst mduReady",   32'(bus.mduReady),   32'd0);
    check("prerst pendingHit", 32'(bus.pendingHit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd8);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("postrst%0d regWrite", c),   32'(bus.regWrite),   32'd0);
      check($sformatf("postrst%0d pendingHit", c), 32'(bus.pendingHit), 32'd0);
      check($sformatf("postrst%0d mduReady", c),   32'(bus.mduReady),   32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
